// File: rtl/uart_hex32_rx_parser.sv
// rtl/uart_hex32_rx_parser.sv - byte-stream hex token parser producing 32-bit words.
module uart_hex32_rx_parser #(
  parameter logic [23:0] TIMEOUT = 24'd0
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  output logic [31:0] value,
  output logic        value_strobe,
  output logic [3:0]  digit_count,
  output logic        error_strobe,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [23:0] tmo, tmo_nxt;
  logic [31:0] value_nxt;
  logic [3:0]  digit_count_nxt;
  logic        value_strobe_nxt, error_strobe_nxt;

  logic        is_digit, is_term, tmo_hit;
  logic [3:0]  nibble;

  // 0x30-0x3F is accepted whole so the {4'h3,nibble} transmit encoding round-trips.
  always_comb begin
    is_digit = 1'b0;
    nibble   = rx_data[3:0];
    if (rx_data[7:4] == 4'h3) begin
      is_digit = 1'b1;
    end else if ((rx_data[7:4] == 4'h4 || rx_data[7:4] == 4'h6) &&
                 rx_data[3:0] >= 4'd1 && rx_data[3:0] <= 4'd6) begin
      is_digit = 1'b1;
      nibble   = rx_data[3:0] + 4'd9;
    end
    is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A) ||
              (rx_data == 8'h20) || (rx_data == 8'h2C);
  end

  assign tmo_hit = (TIMEOUT != 24'd0) && (tmo == TIMEOUT);

  always_comb begin
    state_nxt        = state;
    acc_nxt          = acc;
    cnt_nxt          = cnt;
    tmo_nxt          = tmo;
    value_nxt        = value;
    digit_count_nxt  = digit_count;
    value_strobe_nxt = 1'b0;
    error_strobe_nxt = 1'b0;

    if (rx_strobe) begin
      tmo_nxt = 24'd0;
      case (state)
        IDLE: begin
          if (is_digit) begin
            acc_nxt   = {28'd0, nibble};
            cnt_nxt   = 4'd1;
            state_nxt = ACCUM;
          end else if (!is_term) begin
            error_strobe_nxt = 1'b1;
            state_nxt        = SKIP;
          end
        end
        ACCUM: begin
          if (is_digit) begin
            if (cnt == 4'd8) begin
              error_strobe_nxt = 1'b1;
              state_nxt        = SKIP;
            end else begin
              acc_nxt = {acc[27:0], nibble};
              cnt_nxt = cnt + 4'd1;
            end
          end else if (is_term) begin
            value_nxt        = acc;
            digit_count_nxt  = cnt;
            value_strobe_nxt = 1'b1;
            state_nxt        = IDLE;
          end else begin
            error_strobe_nxt = 1'b1;
            state_nxt        = SKIP;
          end
        end
        SKIP: begin
          if (is_term) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tmo_hit) begin
        error_strobe_nxt = (state == ACCUM);
        acc_nxt          = 32'd0;
        cnt_nxt          = 4'd0;
        state_nxt        = IDLE;
      end else if (tmo != TIMEOUT) begin
        tmo_nxt = tmo + 24'd1;
      end
    end

    if (state_nxt == IDLE) tmo_nxt = 24'd0;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= 32'd0;
      cnt          <= 4'd0;
      tmo          <= 24'd0;
      value        <= 32'd0;
      digit_count  <= 4'd0;
      value_strobe <= 1'b0;
      error_strobe <= 1'b0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      cnt          <= cnt_nxt;
      tmo          <= tmo_nxt;
      value        <= value_nxt;
      digit_count  <= digit_count_nxt;
      value_strobe <= value_strobe_nxt;
      error_strobe <= error_strobe_nxt;
    end
  end

  assign busy = (state == ACCUM) || (state == SKIP);

endmodule

// File: tb/tb_uart_hex32_rx_parser.sv
// tb/tb_uart_hex32_rx_parser.sv - scoreboard bench for uart_hex32_rx_parser.
`timescale 1ns/1ps
module tb_uart_hex32_rx_parser;

  localparam int K_NONE = 0;
  localparam int K_VAL  = 1;
  localparam int K_ERR  = 2;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_strobe = 1'b0;
  logic [31:0] value;
  logic        value_strobe;
  logic [3:0]  digit_count;
  logic        error_strobe;
  logic        busy;

  uart_hex32_rx_parser #(.TIMEOUT(24'd16)) dut (
    .mclk(mclk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_strobe(rx_strobe),
    .value(value),
    .value_strobe(value_strobe),
    .digit_count(digit_count),
    .error_strobe(error_strobe),
    .busy(busy)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [3:0]  dc;
    int          at;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge mclk) begin
    if (!reset && (value_strobe || error_strobe)) begin
      chk("strobe_exclusive", {31'd0, value_strobe & error_strobe}, 32'd0);
      if (sb.size() == 0) begin
        chk("spurious_strobe", {30'd0, value_strobe, error_strobe}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_kind", value_strobe ? K_VAL : K_ERR, mon_e.kind);
        chk("strobe_cycle", cyc, mon_e.at);
        chk("value", value, mon_e.val);
        chk("digit_count", {28'd0, digit_count}, {28'd0, mon_e.dc});
      end
    end
  end

  task automatic expect_at(input int kind, input logic [31:0] v, input logic [3:0] dc, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = v;
    e.dc   = dc;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [7:0] b, input int kind, input logic [31:0] v, input logic [3:0] dc);
    if (kind != K_NONE) expect_at(kind, v, dc, cyc + 1);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(negedge mclk);
    rx_strobe = 1'b0;
    rx_data   = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], K_NONE, 32'd0, 4'd0);
      idle(gap);
    end
  endtask

  initial begin
    idle(3);
    chk("reset_value", value, 32'd0);
    chk("reset_dc", {28'd0, digit_count}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_strobes", {30'd0, value_strobe, error_strobe}, 32'd0);
    reset = 1'b0;
    idle(2);

    send_str("DEADBEEF", 3);
    chk("busy_accum", {31'd0, busy}, 32'd1);
    send(8'h0D, K_VAL, 32'hDEADBEEF, 4'd8);
    idle(3);

    send_str("0123:;<=", 0);
    send(8'h0A, K_VAL, 32'h0123ABCD, 4'd8);
    idle(2);

    send_str("12345678", 0);
    send("9", K_ERR, 32'h0123ABCD, 4'd8);
    send(" ", K_NONE, 32'd0, 4'd0);
    send("7", K_NONE, 32'd0, 4'd0);
    send(",", K_VAL, 32'h7, 4'd1);
    idle(2);

    send_str("12", 1);
    send("G", K_ERR, 32'h7, 4'd1);
    send_str("4\r\r\r 5", 1);
    send(8'h0D, K_VAL, 32'h5, 4'd1);
    idle(2);

    send_str("abcdef01", 0);
    send(8'h0D, K_VAL, 32'hABCDEF01, 4'd8);
    idle(2);

    send("x", K_ERR, 32'hABCDEF01, 4'd8);
    send_str("5 9", 0);
    send(8'h0D, K_VAL, 32'h9, 4'd1);
    idle(2);

    // ACCUM timeout: counter reaches 16 after 16 idle edges, expiry edge is the 17th.
    send_str("AB", 0);
    expect_at(K_ERR, 32'h9, 4'd1, cyc + 17);
    idle(10);
    chk("busy_before_timeout", {31'd0, busy}, 32'd1);
    idle(10);
    chk("busy_after_timeout", {31'd0, busy}, 32'd0);
    send(8'h0D, K_NONE, 32'd0, 4'd0);
    idle(2);
    chk("value_held", value, 32'h9);

    send("x", K_ERR, 32'h9, 4'd1);
    idle(20);
    chk("busy_after_skip_timeout", {31'd0, busy}, 32'd0);
    send("3", K_NONE, 32'd0, 4'd0);
    send(8'h0D, K_VAL, 32'h3, 4'd1);
    idle(2);

    // Byte lands exactly on the expiry edge and must win.
    send("A", K_NONE, 32'd0, 4'd0);
    idle(16);
    send("B", K_NONE, 32'd0, 4'd0);
    send(8'h0D, K_VAL, 32'hAB, 4'd2);
    idle(2);

    send_str("AB", 0);
    chk("busy_pre_reset", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_value", value, 32'd0);
    chk("async_reset_dc", {28'd0, digit_count}, 32'd0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_strobes", {30'd0, value_strobe, error_strobe}, 32'd0);
    #1 reset = 1'b0;
    @(negedge mclk);
    send("C", K_NONE, 32'd0, 4'd0);
    send(8'h0D, K_VAL, 32'hC, 4'd1);

    idle(10);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
